// File: rtl/shift_src.sv
// Sequenced shift/rotate/LFSR source register feeding the barrel shifter din.
// Optional feature: define SHIFT_SRC_LFSR_EN to enable the op 111 LFSR step.
module shift_src #(
  parameter logic [7:0] SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] op,
  input  logic [2:0] reps,
  input  logic [7:0] load_data,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic       sin,
  output logic [7:0] q,
  output logic       q_valid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_CLR  = 3'b000;
  localparam logic [2:0] OP_LD   = 3'b001;
  localparam logic [2:0] OP_LSR  = 3'b010;
  localparam logic [2:0] OP_ASR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ROL  = 3'b110;
  localparam logic [2:0] OP_LFSR = 3'b111;

  state_t     state_r;
  logic [2:0] op_r;
  logic [2:0] cnt_r;
  logic [7:0] ld_r;

`ifndef SHIFT_SRC_LFSR_EN
  logic [7:0] seed_unused_s;
  assign seed_unused_s = SEED;
`endif

  // One iteration of the captured operation applied to the current value.
  function automatic logic [7:0] step_f(input logic [2:0] o, input logic [7:0] v,
                                        input logic [7:0] ld, input logic s);
    logic [7:0] r;
    case (o)
      OP_CLR:  r = 8'h00;
      OP_LD:   r = ld;
      OP_LSR:  r = {1'b0, v[7:1]};
      OP_ASR:  r = {v[7], v[7:1]};
      OP_SHL:  r = {v[6:0], s};
      OP_ROR:  r = {v[0], v[7:1]};
      OP_ROL:  r = {v[6:0], v[7]};
`ifdef SHIFT_SRC_LFSR_EN
      OP_LFSR: r = (v == 8'h00) ? SEED : {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
`else
      OP_LFSR: r = v;
`endif
      default: r = v;
    endcase
    return r;
  endfunction

  // Request capture, per-cycle iteration, and registered handshake/valid outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      q        <= 8'h00;
      q_valid  <= 1'b0;
      op_ready <= 1'b1;
      cnt_r    <= 3'd0;
      op_r     <= 3'd0;
      ld_r     <= 8'h00;
    end else begin
      case (state_r)
        IDLE: begin
          q_valid <= 1'b0;
          if (op_valid && op_ready) begin
            op_r     <= op;
            ld_r     <= load_data;
            // clear and load are one-shot whatever reps says
            cnt_r    <= ((op == OP_CLR) || (op == OP_LD)) ? 3'd0 : reps;
            op_ready <= 1'b0;
            state_r  <= RUN;
          end else begin
            op_ready <= 1'b1;
          end
        end
        RUN: begin
          q <= step_f(op_r, q, ld_r, sin);
          if (cnt_r == 3'd0) begin
            q_valid <= 1'b1;
            state_r <= DONE;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        DONE: begin
          q_valid  <= 1'b0;
          op_ready <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          q_valid  <= 1'b0;
          op_ready <= 1'b1;
          cnt_r    <= 3'd0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_src.sv
// Randomised plus directed bench for shift_src against an arithmetic reference model.
module tb_shift_src;

  localparam logic [7:0] SEED = 8'h01;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op;
  logic [2:0] reps;
  logic [7:0] load_data;
  logic       op_valid;
  logic       op_ready;
  logic       sin;
  logic [7:0] q;
  logic       q_valid;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] model_q;

  shift_src #(.SEED(SEED)) dut (
    .clk(clk), .rst(rst), .op(op), .reps(reps), .load_data(load_data),
    .op_valid(op_valid), .op_ready(op_ready), .sin(sin), .q(q), .q_valid(q_valid)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_step(input logic [2:0] o, input logic [7:0] v,
                                            input logic [7:0] ld, input logic s);
    logic [7:0] fb;
    case (o)
      3'd0: return 8'h00;
      3'd1: return ld;
      3'd2: return v >> 1;
      3'd3: return (v >> 1) | (v & 8'h80);
      3'd4: return (v << 1) | {7'd0, s};
      3'd5: return (v >> 1) | (v << 7);
      3'd6: return (v << 1) | (v >> 7);
      default: begin
`ifdef SHIFT_SRC_LFSR_EN
        if (v == 8'h00) return SEED;
        fb = {^(v & 8'h1D), 7'd0};
        return (v >> 1) | fb;
`else
        fb = 8'h00;
        return v | fb;
`endif
      end
    endcase
  endfunction

  // Issue one request at a falling edge in IDLE; checks every RUN/DONE cycle and returns in IDLE.
  task automatic run_op(input logic [2:0] o, input logic [2:0] r, input logic [7:0] d,
                        input logic [7:0] sb);
    logic [7:0] exp_q [0:8];
    int iters;
    int cyc;
    bit seen;
    iters = (o <= 3'd1) ? 1 : int'(r) + 1;
    exp_q[0] = model_q;
    for (int i = 1; i <= iters; i++) exp_q[i] = model_step(o, exp_q[i-1], d, sb[i-1]);
    check_val("rdy_idle", {31'd0, op_ready}, 32'd1);
    op_valid = 1'b1; op = o; reps = r; load_data = d; sin = sb[0];
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (q_valid) begin
        seen = 1'b1;
        op_valid = 1'b0;
      end else begin
        check_val("rdy_busy", {31'd0, op_ready}, 32'd0);
        if (cyc <= iters) check_val("q_run", {24'd0, q}, {24'd0, exp_q[cyc-1]});
        sin = (cyc <= 8) ? sb[cyc-1] : 1'b0;
        // garbage requests while busy must be ignored
        op_valid = 1'($urandom);
        op = 3'($urandom); reps = 3'($urandom); load_data = 8'($urandom);
      end
    end
    op_valid = 1'b0;
    check_val("qv_latency", cyc, iters + 1);
    check_val("q_done", {24'd0, q}, {24'd0, exp_q[iters]});
    model_q = exp_q[iters];
    @(negedge clk);
    check_val("qv_pulse", {31'd0, q_valid}, 32'd0);
    check_val("rdy_back", {31'd0, op_ready}, 32'd1);
    check_val("q_hold", {24'd0, q}, {24'd0, model_q});
  endtask

  initial begin
    rst = 1'b1; op = 3'd0; reps = 3'd0; load_data = 8'h00; op_valid = 1'b0; sin = 1'b0;
    model_q = 8'h00;
    repeat (2) @(negedge clk);
    check_val("rst_q", {24'd0, q}, 32'd0);
    check_val("rst_rdy", {31'd0, op_ready}, 32'd1);
    check_val("rst_qv", {31'd0, q_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(3'd1, 3'd5, 8'hB4, 8'h00);
    run_op(3'd3, 3'd2, 8'h00, 8'h00);
    check_val("asr_b4", {24'd0, q}, 32'h0000_00F6);

    run_op(3'd1, 3'd0, 8'h81, 8'h00);
    run_op(3'd6, 3'd7, 8'h00, 8'h00);
    check_val("rol_wrap", {24'd0, q}, 32'h0000_0081);

    run_op(3'd0, 3'd3, 8'hFF, 8'h00);
    run_op(3'd4, 3'd3, 8'h00, 8'b0000_1101);
    check_val("shl_fill", {24'd0, q}, 32'h0000_000B);

`ifdef SHIFT_SRC_LFSR_EN
    run_op(3'd0, 3'd0, 8'h00, 8'h00);
    run_op(3'd7, 3'd0, 8'h00, 8'h00);
    check_val("lfsr_seed", {24'd0, q}, 32'h0000_0001);
    run_op(3'd7, 3'd0, 8'h00, 8'h00);
    check_val("lfsr_step", {24'd0, q}, 32'h0000_0080);
`else
    run_op(3'd1, 3'd0, 8'h5A, 8'h00);
    run_op(3'd7, 3'd4, 8'h00, 8'h00);
    check_val("lfsr_off", {24'd0, q}, 32'h0000_005A);
`endif

    for (int k = 0; k < 40; k++)
      run_op(3'($urandom), 3'($urandom), 8'($urandom), 8'($urandom));

    // reset in the middle of a long logical shift
    run_op(3'd1, 3'd0, 8'hFF, 8'h00);
    op_valid = 1'b1; op = 3'd2; reps = 3'd7;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("mid_rst_q", {24'd0, q}, 32'd0);
    check_val("mid_rst_rdy", {31'd0, op_ready}, 32'd1);
    check_val("mid_rst_qv", {31'd0, q_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_q = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_val("post_rst_qv", {31'd0, q_valid}, 32'd0);
      check_val("post_rst_q", {24'd0, q}, 32'd0);
    end
    run_op(3'd1, 3'd0, 8'h3C, 8'h00);
    run_op(3'd5, 3'd1, 8'h00, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_src.md
SHIFT_SRC -- requirements
Module: shift_src

Interface
REQ-001 The block SHALL have parameter SEED, default 8'h01: the value loaded by an LFSR step from an all-zero register.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port op, input, 3 bits: operation code, sampled at handshake.
REQ-005 The block SHALL have port reps, input, 3 bits: iteration count minus one (1..8 iterations), sampled at handshake.
REQ-006 The block SHALL have port load_data, input, 8 bits: operand for load, sampled at handshake.
REQ-007 The block SHALL have port op_valid, input, 1 bit: a request is present.
REQ-008 The block SHALL have port op_ready, output, 1 bit: the block accepts a request this cycle.
REQ-009 The block SHALL have port sin, input, 1 bit: serial input bit, sampled live on every RUN cycle.
REQ-010 The block SHALL have port q, output, 8 bits: register value, which drives the downstream barrel shifter din.
REQ-011 The block SHALL have port q_valid, output, 1 bit: one-cycle pulse marking q final after a request.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 op_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted when op_valid=1 and op_ready=1 on a rising edge; op, reps and load_data SHALL be captured and the FSM SHALL move IDLE->RUN.
REQ-015 In RUN, exactly one iteration of the captured op SHALL be applied to q per cycle, and a remaining-count register SHALL decrement once per iteration.
REQ-016 The FSM SHALL move RUN->DONE on the cycle the last iteration is applied.
REQ-017 Ops 000 (clear, q=0) and 001 (load, q=load_data) SHALL be single iteration regardless of reps, giving RUN for exactly 1 cycle.
REQ-018 Op 010 SHALL perform a logical right shift by 1 with 0 into q[7].
REQ-019 Op 011 SHALL perform an arithmetic right shift by 1, with q[7] preserved.
REQ-020 Op 100 SHALL perform a left shift by 1 with sin into q[0].
REQ-021 Op 101 SHALL rotate right by 1 (q[0] into q[7]).
REQ-022 Op 110 SHALL rotate left by 1 (q[7] into q[0]).
REQ-023 Op 111 SHALL perform an LFSR step: q = {q[4]^q[3]^q[2]^q[0], q[7:1]}; if q==8'h00 before the step, q SHALL become SEED instead.
REQ-024 Latency SHALL be handshake edge + (iterations) RUN cycles + 1 DONE cycle, after which the FSM SHALL return to IDLE.
REQ-025 q_valid SHALL be 1 for exactly the DONE cycle and 0 otherwise.
REQ-026 q SHALL hold its value in IDLE and DONE.
REQ-027 op_valid asserted while the block is not in IDLE SHALL be ignored, with no capture and no effect; the requester holds it until op_ready.
REQ-028 A new request SHALL be acceptable on the first IDLE cycle after DONE, so back-to-back requests cost one idle cycle minimum.
REQ-029 Intermediate q values during RUN SHALL be visible on the q port but are not qualified by q_valid.

Reset
REQ-030 Asserting rst SHALL, asynchronously and at any state including mid-RUN, force state=IDLE, q=8'h00, q_valid=0, op_ready=1 and remaining count=0.
REQ-031 Deassertion of rst SHALL be followed by normal operation from the next rising clk; an interrupted request SHALL be lost.

Configuration
REQ-032 With macro SHIFT_SRC_LFSR_EN defined, op 111 SHALL behave per REQ-023.
REQ-033 Without SHIFT_SRC_LFSR_EN, op 111 SHALL leave q unchanged each iteration while still consuming the iteration count and producing the q_valid pulse; SEED SHALL then be unused.

Verification
REQ-034 The bench SHALL cover load then multi-iteration shift: load 8'hB4, then op 011 reps 2 -> q_valid pulse once, q=8'hF6, and op_ready low for 4 cycles after the second handshake.
REQ-035 The bench SHALL cover rotate wrap: load 8'h81, op 110 reps 7 (8 iterations) -> q=8'h81 at the q_valid pulse.
REQ-036 The bench SHALL cover serial fill: clear, then op 100 reps 3 with sin=1,0,1,1 on successive RUN cycles -> q=8'h0B.
REQ-037 The bench SHALL cover LFSR lock-up escape with SHIFT_SRC_LFSR_EN defined: clear, op 111 reps 0 -> q=8'h01; op 111 reps 0 again -> q=8'h80.
REQ-038 The bench SHALL cover the LFSR-disabled build: without SHIFT_SRC_LFSR_EN, load 8'h5A, op 111 reps 4 -> q=8'h5A, with q_valid 6 cycles after the handshake edge.
REQ-039 The bench SHALL cover reset mid-RUN: op 010 reps 7 on 8'hFF, then assert rst on the 3rd RUN cycle -> q=8'h00, op_ready=1 immediately, and no q_valid pulse.
